// File: rtl/countdown_pkg.sv
// Shared countdown/stopwatch definitions: run-control states, BCD digit maxima,
// the seven-segment code table and preset clamping.
package countdown_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Field order matches the preset bus: h10 sits in [23:20].
  typedef struct packed {
    logic [3:0] h10;
    logic [3:0] h1;
    logic [3:0] m10;
    logic [3:0] m1;
    logic [3:0] s10;
    logic [3:0] s1;
  } bcd_time_t;

  localparam logic [3:0] DIGIT_MAX = 4'd9;
  localparam logic [3:0] TENS_MAX  = 4'd5;
  localparam logic [3:0] H10_MAX   = 4'd2;
  localparam logic [3:0] H1_MAX_23 = 4'd3;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;

  function automatic bcd_time_t clamp_preset(input bcd_time_t p);
    bcd_time_t c;
    c = p;
    if (c.h10 > DIGIT_MAX) c.h10 = DIGIT_MAX;
    if (c.h1  > DIGIT_MAX) c.h1  = DIGIT_MAX;
    if (c.m10 > TENS_MAX)  c.m10 = TENS_MAX;
    if (c.m1  > DIGIT_MAX) c.m1  = DIGIT_MAX;
    if (c.s10 > TENS_MAX)  c.s10 = TENS_MAX;
    if (c.s1  > DIGIT_MAX) c.s1  = DIGIT_MAX;
    // Anything past 23 hours saturates to 23, minutes/seconds keep their clamped values.
    if ((c.h10 > H10_MAX) || ((c.h10 == H10_MAX) && (c.h1 > H1_MAX_23))) begin
      c.h10 = H10_MAX;
      c.h1  = H1_MAX_23;
    end
    return c;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// BCD digit to active-high {g,f,e,d,c,b,a} segments; purely combinational.
// Zero latency, no flow control.
module seg7_decoder
  import countdown_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h00;
    case (digit)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = 7'h00;
    endcase
  end

endmodule

// File: rtl/countdown_timer.sv
// HH:MM:SS countdown with run/pause/done control; state changes on the edge sampling start_stop,
// first decrement TICKS_PER_SEC edges into RUN, segments combinational from digits; no backpressure.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int TICKS_PER_SEC = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_stop,
  input  logic        load,
  input  logic [23:0] preset,
  output logic [6:0]  h10,
  output logic [6:0]  h1,
  output logic [6:0]  m10,
  output logic [6:0]  m1,
  output logic [6:0]  s10,
  output logic [6:0]  s1,
  output logic        done,
  output logic        running
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

  state_t         state;
  bcd_time_t      cnt;
  bcd_time_t      dec;
  logic [PW-1:0]  presc;
  logic           start_d;
  logic           start_edge;

  assign start_edge = start_stop & ~start_d;

  // One-second borrow chain; never used while the count is already zero.
  always_comb begin
    dec = cnt;
    if (cnt.s1 != 4'd0) begin
      dec.s1 = cnt.s1 - 4'd1;
    end else begin
      dec.s1 = DIGIT_MAX;
      if (cnt.s10 != 4'd0) begin
        dec.s10 = cnt.s10 - 4'd1;
      end else begin
        dec.s10 = TENS_MAX;
        if (cnt.m1 != 4'd0) begin
          dec.m1 = cnt.m1 - 4'd1;
        end else begin
          dec.m1 = DIGIT_MAX;
          if (cnt.m10 != 4'd0) begin
            dec.m10 = cnt.m10 - 4'd1;
          end else begin
            dec.m10 = TENS_MAX;
            if (cnt.h1 != 4'd0) begin
              dec.h1 = cnt.h1 - 4'd1;
            end else begin
              dec.h1  = DIGIT_MAX;
              dec.h10 = cnt.h10 - 4'd1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      presc   <= '0;
      start_d <= 1'b0;
      done    <= 1'b0;
      running <= 1'b0;
    end else begin
      start_d <= start_stop;
      if (load) begin
        cnt     <= clamp_preset(bcd_time_t'(preset));
        presc   <= '0;
        state   <= IDLE;
        done    <= 1'b0;
        running <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start_edge && (cnt != '0)) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          RUN: begin
            // A pause edge freezes the prescaler so the second keeps its phase.
            if (start_edge) begin
              state   <= PAUSE;
              running <= 1'b0;
            end else if (presc == PRESC_LAST) begin
              presc <= '0;
              cnt   <= dec;
              if (dec == '0) begin
                state   <= DONE;
                running <= 1'b0;
                done    <= 1'b1;
              end
            end else begin
              presc <= presc + PW'(1);
            end
          end
          PAUSE: begin
            if (start_edge) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          DONE: begin
            presc <= '0;
            if (start_edge) begin
              state <= IDLE;
              done  <= 1'b0;
            end
          end
          default: begin
            state   <= IDLE;
            running <= 1'b0;
            done    <= 1'b0;
          end
        endcase
      end
    end
  end

  seg7_decoder u_dec_h10 (.digit(cnt.h10), .seg(h10));
  seg7_decoder u_dec_h1  (.digit(cnt.h1),  .seg(h1));
  seg7_decoder u_dec_m10 (.digit(cnt.m10), .seg(m10));
  seg7_decoder u_dec_m1  (.digit(cnt.m1),  .seg(m1));
  seg7_decoder u_dec_s10 (.digit(cnt.s10), .seg(s10));
  seg7_decoder u_dec_s1  (.digit(cnt.s1),  .seg(s1));

endmodule

// File: tb/tb_countdown_timer.sv
// Directed plus randomized bench for countdown_timer, checked against a seconds-based model.
module tb_countdown_timer;

  localparam int TPS = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_stop = 1'b0;
  logic        load = 1'b0;
  logic [23:0] preset = 24'h0;
  logic [6:0]  h10, h1, m10, m1, s10, s1;
  logic        done, running;

  int passed = 0;
  int total  = 0;

  // Reference model: remaining time as plain seconds, mode 0 idle 1 run 2 pause 3 done.
  int m_secs  = 0;
  int m_mode  = 0;
  int m_phase = 0;
  bit m_prev  = 1'b0;

  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  countdown_timer #(.TICKS_PER_SEC(TPS)) dut (
    .clk(clk), .rst(rst), .start_stop(start_stop), .load(load), .preset(preset),
    .h10(h10), .h1(h1), .m10(m10), .m1(m1), .s10(s10), .s1(s1),
    .done(done), .running(running)
  );

  always #5 clk = ~clk;

  function automatic int clamp_secs(input logic [23:0] p);
    int d [6];
    int hrs;
    for (int i = 0; i < 6; i++) begin
      d[i] = int'(p[23 - 4*i -: 4]);
      if (d[i] > 9) d[i] = 9;
    end
    if (d[2] > 5) d[2] = 5;
    if (d[4] > 5) d[4] = 5;
    hrs = d[0] * 10 + d[1];
    if (hrs > 23) hrs = 23;
    return hrs * 3600 + (d[2] * 10 + d[3]) * 60 + d[4] * 10 + d[5];
  endfunction

  task automatic model_reset();
    m_secs = 0; m_mode = 0; m_phase = 0; m_prev = 1'b0;
  endtask

  task automatic model_clock(input logic ss, input logic ld, input logic [23:0] pr);
    bit edge_seen;
    edge_seen = ss && !m_prev;
    m_prev = ss;
    if (ld) begin
      m_secs = clamp_secs(pr); m_phase = 0; m_mode = 0;
    end else begin
      case (m_mode)
        0: if (edge_seen && m_secs != 0) m_mode = 1;
        1: begin
          if (edge_seen) m_mode = 2;
          else begin
            m_phase++;
            if (m_phase == TPS) begin
              m_phase = 0;
              m_secs--;
              if (m_secs == 0) m_mode = 3;
            end
          end
        end
        2: if (edge_seen) m_mode = 1;
        default: begin
          m_phase = 0;
          if (edge_seen) m_mode = 0;
        end
      endcase
    end
  endtask

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_model(input string tag);
    int hh, mm, ss;
    hh = m_secs / 3600;
    mm = (m_secs / 60) % 60;
    ss = m_secs % 60;
    chk({tag, ".h10"}, h10, seg_tab[hh / 10]);
    chk({tag, ".h1"},  h1,  seg_tab[hh % 10]);
    chk({tag, ".m10"}, m10, seg_tab[mm / 10]);
    chk({tag, ".m1"},  m1,  seg_tab[mm % 10]);
    chk({tag, ".s10"}, s10, seg_tab[ss / 10]);
    chk({tag, ".s1"},   s1, seg_tab[ss % 10]);
    chk({tag, ".done"},    {6'd0, done},    {6'd0, m_mode == 3});
    chk({tag, ".running"}, {6'd0, running}, {6'd0, m_mode == 1});
  endtask

  // Apply inputs, take one clock edge, advance the model, settle before sampling.
  task automatic step(input logic ss, input logic ld, input logic [23:0] pr);
    start_stop = ss; load = ld; preset = pr;
    @(posedge clk);
    model_clock(ss, ld, pr);
    #1;
  endtask

  task automatic steps(input int n, input logic ss);
    for (int i = 0; i < n; i++) step(ss, 1'b0, 24'h0);
  endtask

  initial begin
    #1 rst = 1'b1;
    model_reset();
    #1;
    chk("reset_async.s1", s1, 7'h3F);
    chk("reset_async.h10", h10, 7'h3F);
    check_model("reset");
    @(posedge clk); #1 rst = 1'b0;

    // 00:00:03 countdown to done.
    step(1'b0, 1'b1, 24'h000003);
    step(1'b0, 1'b0, 24'h0);
    step(1'b1, 1'b0, 24'h0);
    chk("cd3.running", {6'd0, running}, 7'd1);
    chk("cd3.s1_start", s1, 7'h4F);
    for (int c = 1; c <= 12; c++) begin
      step(1'b1, 1'b0, 24'h0);
      check_model("cd3");
      if (c == 4)  chk("cd3.s1_c4", s1, 7'h5B);
      if (c == 8)  chk("cd3.s1_c8", s1, 7'h06);
      if (c == 11) chk("cd3.done_c11", {6'd0, done}, 7'd0);
    end
    chk("cd3.s1_c12", s1, 7'h3F);
    chk("cd3.done_c12", {6'd0, done}, 7'd1);
    step(1'b0, 1'b0, 24'h0);
    step(1'b1, 1'b0, 24'h0);
    chk("cd3.done_cleared", {6'd0, done}, 7'd0);
    check_model("cd3_idle");

    // Hour borrow 10:00:00 -> 09:59:59.
    step(1'b0, 1'b1, 24'h100000);
    step(1'b1, 1'b0, 24'h0);
    steps(4, 1'b0);
    chk("borrow.h10", h10, 7'h3F);
    chk("borrow.h1",  h1,  7'h6F);
    chk("borrow.m10", m10, 7'h6D);
    chk("borrow.m1",  m1,  7'h6F);
    chk("borrow.s10", s10, 7'h6D);
    chk("borrow.s1",  s1,  7'h6F);

    // Pause keeps the prescaler phase.
    step(1'b0, 1'b1, 24'h000005);
    step(1'b1, 1'b0, 24'h0);
    steps(1, 1'b0);
    step(1'b0, 1'b0, 24'h0);
    step(1'b1, 1'b0, 24'h0);
    for (int c = 0; c < 20; c++) step(1'b0, 1'b0, 24'h0);
    chk("pause.hold_s1", s1, 7'h6D);
    chk("pause.hold_running", {6'd0, running}, 7'd0);
    step(1'b1, 1'b0, 24'h0);
    step(1'b0, 1'b0, 24'h0);
    chk("pause.resume1_s1", s1, 7'h6D);
    step(1'b0, 1'b0, 24'h0);
    chk("pause.resume2_s1", s1, 7'h66);
    check_model("pause");

    // Clamping of an all-nines preset.
    step(1'b0, 1'b1, 24'h999999);
    chk("clamp.h10", h10, 7'h5B);
    chk("clamp.h1",  h1,  7'h4F);
    chk("clamp.m10", m10, 7'h6D);
    chk("clamp.s1",  s1,  7'h6F);
    check_model("clamp");

    // Load beats a simultaneous start edge in RUN.
    step(1'b0, 1'b1, 24'h000015);
    step(1'b1, 1'b0, 24'h0);
    step(1'b0, 1'b0, 24'h0);
    step(1'b1, 1'b1, 24'h000042);
    chk("loadwin.running", {6'd0, running}, 7'd0);
    chk("loadwin.s10", s10, 7'h66);
    chk("loadwin.s1",  s1,  7'h5B);
    step(1'b0, 1'b0, 24'h0);
    step(1'b1, 1'b0, 24'h0);
    chk("loadwin.idle_restart", {6'd0, running}, 7'd1);

    // Start at zero is ignored.
    step(1'b0, 1'b1, 24'h000000);
    step(1'b0, 1'b0, 24'h0);
    step(1'b1, 1'b0, 24'h0);
    chk("zero_start.running", {6'd0, running}, 7'd0);
    check_model("zero_start");

    // Asynchronous reset in the middle of RUN.
    step(1'b0, 1'b1, 24'h012345);
    step(1'b1, 1'b0, 24'h0);
    steps(6, 1'b0);
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("midreset.s1", s1, 7'h3F);
    chk("midreset.running", {6'd0, running}, 7'd0);
    check_model("midreset");
    @(posedge clk); #1 rst = 1'b0;

    // Randomized traffic against the model.
    for (int it = 0; it < 600; it++) begin
      logic ss, ld;
      logic [23:0] pr;
      int kind;
      ss = ($urandom_range(0, 11) == 0);
      ld = ($urandom_range(0, 39) == 0);
      kind = $urandom_range(0, 2);
      if (kind == 0)
        pr = {16'h0, 4'($urandom_range(0, 1)), 4'($urandom_range(0, 9))};
      else if (kind == 1)
        pr = {4'($urandom_range(0, 1)), 4'h0, 8'h00, 4'h0, 4'($urandom_range(0, 2))};
      else
        pr = 24'($urandom());
      step(ss, ld, pr);
      check_model("rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Countdown companion to the stopwatch: the same six-digit HH:MM:SS seven-segment display, but it counts down from a loaded preset to 00:00:00 and then raises a done flag. It uses the same clk, rst and start_stop conventions as the stopwatch top, so the two can share one board wrapper and one display driver. The block contains the run-control FSM, the one-second prescaler, the BCD borrow chain and the digit-to-segment decoding.

## Interface
- TICKS_PER_SEC, default 100: clk cycles per one-second tick. Must be ≥2.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start_stop  in  1  run/pause control. Each rising edge is one command. The input is synchronous to clk.
- load  in  1  level. Loads the preset into the digits in any state.
- preset  in  24  BCD digits {h10,h1,m10,m1,s10,s1}, 4 bits each, h10 in [23:20].
- h10,h1,m10,m1,s10,s1  out  7 each  segments {g,f,e,d,c,b,a}, active-high.
- done  out  1  high while in DONE.
- running  out  1  high while in RUN.

## Operation
- States: IDLE, RUN, PAUSE, DONE.
- Start edge detection: start_d registers start_stop. An edge is start_stop & ~start_d.
- IDLE:
  - Edge with a nonzero count goes to RUN.
  - Edge with a zero count is ignored.
- RUN:
  - The prescaler counts 0..TICKS_PER_SEC-1 and a tick fires when it is at TICKS_PER_SEC-1.
  - Each tick decrements the count by one second.
  - If the decrement lands on 00:00:00, go to DONE.
  - An edge goes to PAUSE.
- PAUSE: the prescaler and digits hold. An edge resumes RUN from the held prescaler value.
- DONE: the count stays 00:00:00 and the prescaler is cleared. An edge goes to IDLE.
- load (any state):
  - Loads the digits from preset, clears the prescaler, goes to IDLE.
  - Wins over a simultaneous start edge and over a simultaneous tick.
- Load clamping, applied per digit:
  - s10 >5 → 5, m10 >5 → 5.
  - Any digit >9 → 9.
  - If the clamped hours exceed 23, hours load as 23.
  - Example: preset all 9s loads 23:59:59.
- Borrow chain:
  - s1 0→9 borrows from s10; s10 0→5 borrows from m1.
  - m1 0→9 borrows from m10; m10 0→5 borrows from h1.
  - h1 0→9 borrows from h10.
  - Example: 10:00:00 → 09:59:59.
  - Decrement is never applied at 00:00:00.
- Segment codes, digits 0–9: 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F. Codes >9 cannot occur.

## Timing
- Reset values: state IDLE, digits 00:00:00, all six segment outputs 7'h3F, done 0, running 0, prescaler 0, start_d 0.
- Reset is asynchronous. Outputs reach reset values without a clock edge. Reset mid-RUN discards the count.
- A start edge sampled at clk edge N changes the state at edge N. running changes at edge N.
- Segment outputs decode the digit registers combinationally. They change right after the edge that updates the digits.
- Tick latency: after entering RUN from IDLE, the first decrement occurs at the TICKS_PER_SEC-th clock edge in RUN.
- done rises at the same edge at which the digits become 00:00:00.
- Pause/resume keeps phase: total RUN cycles between decrements is always TICKS_PER_SEC.
- start_stop held high produces exactly one edge.

## Structure
- Shared package countdown_pkg holds:
  - state encoding (IDLE=0, RUN=1, PAUSE=2, DONE=3);
  - the digit maxima constants;
  - the ten segment code constants.
- The segment table is shared with the stopwatch.
- One sub-module, seg7_decoder: 4-bit BCD in, 7-bit segments out, instantiated six times.
- The prescaler, FSM and borrow chain stay in countdown_timer.

## Test plan
All scenarios use TICKS_PER_SEC=4.
- Reset asserted between clock edges → all outputs 7'h3F immediately, done=0, running=0.
- Load 00:00:03, release load, one start edge:
  - running=1;
  - s1 reads 4F, then 5B, then 06 at 4-cycle intervals;
  - at cycle 12 s1=3F and done=1;
  - a further edge → done=0, state IDLE.
- Load 10:00:00, start, 4 cycles → segments h10..s1 = 3F, 6F, 6D, 6F, 6D, 6F (09:59:59).
- Pause timing:
  - Load 00:00:05, start, 2 cycles, edge to pause, hold 20 cycles → s1 stays 6D.
  - Edge to resume → s1 = 66 after exactly 2 more cycles.
- Load with preset all 9s → display 23:59:59 (5B, 4F, 6D, 6F, 6D, 6F).
- load and a start edge in the same cycle during RUN → preset loaded, state IDLE, running=0.
- Start edge in IDLE at 00:00:00 → running stays 0.
